// File: rtl/ascon_pack.sv
// Shared Ascon types: the 5x64 permutation state and the serializer FSM
// encoding, plus the load-configuration check used by the serializer.
package ascon_pack;

    localparam int NB_STATE_WORDS = 5;
    localparam int STATE_WORD_W   = 64;

    typedef logic [NB_STATE_WORDS-1:0][STATE_WORD_W-1:0] type_state;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } type_ser_fsm;

    // Run must start inside the state and not run past word 4.
    // The sum is taken at 4 bits so first=7,count=7 cannot wrap.
    function automatic logic ser_cfg_ok(
        input logic [2:0] first,
        input logic [2:0] count
    );
        logic [3:0] last_excl;
        last_excl = {1'b0, first} + {1'b0, count};
        return (count != 3'd0)
            && (count <= 3'(NB_STATE_WORDS))
            && (last_excl <= 4'(NB_STATE_WORDS));
    endfunction

endpackage

// File: rtl/state_serializer.sv
// Snapshots an Ascon state on load and streams a run of its 64-bit words
// over a valid/ready interface; reports completion and rejected loads.
module state_serializer
    import ascon_pack::*;
(
    input  logic        clock_i,
    input  logic        resetb_i,
    input  type_state   state_i,
    input  logic        load_i,
    input  logic [2:0]  first_i,
    input  logic [2:0]  count_i,
    output logic [63:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        last_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    type_ser_fsm fsm_q, fsm_d;
    type_state   snap_q;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  rem_q, rem_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cfg_ok;
    logic        accept;

    assign cfg_ok = ser_cfg_ok(first_i, count_i);
    assign accept = (fsm_q == IDLE) && load_i && cfg_ok;

    // Next-state logic for the FSM, word pointer, remaining count and pulses.
    always_comb begin
        fsm_d  = fsm_q;
        idx_d  = idx_q;
        rem_d  = rem_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (load_i) begin
                    if (cfg_ok) begin
                        fsm_d = SEND;
                        idx_d = first_i;
                        rem_d = count_i;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                if (ready_i) begin
                    if (rem_q == 3'd1) begin
                        fsm_d  = IDLE;
                        done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        rem_d = rem_q - 3'd1;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Control registers; reset aborts any run without a done pulse.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q  <= IDLE;
            idx_q  <= 3'd0;
            rem_q  <= 3'd0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            idx_q  <= idx_d;
            rem_q  <= rem_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // Snapshot is written only on an accepted load, so the permutation
    // may keep updating state_i while the run is in flight.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            snap_q <= '0;
        end else if (accept) begin
            snap_q <= state_i;
        end
    end

    // Word mux and stream outputs, all decoded from registers only.
    always_comb begin
        data_o  = '0;
        valid_o = 1'b0;
        last_o  = 1'b0;
        busy_o  = 1'b0;
        if (fsm_q == SEND) begin
            valid_o = 1'b1;
            busy_o  = 1'b1;
            last_o  = (rem_q == 3'd1);
            case (idx_q)
                3'd0:    data_o = snap_q[0];
                3'd1:    data_o = snap_q[1];
                3'd2:    data_o = snap_q[2];
                3'd3:    data_o = snap_q[3];
                3'd4:    data_o = snap_q[4];
                default: data_o = '0;
            endcase
        end
    end

    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_state_serializer.sv
// Directed bench for state_serializer: tag run, backpressured full dump,
// load-in-SEND, invalid configs, back-to-back runs and reset mid-run.
module tb_state_serializer;
    import ascon_pack::*;

    logic        clock_i;
    logic        resetb_i;
    type_state   state_i;
    logic        load_i;
    logic [2:0]  first_i;
    logic [2:0]  count_i;
    logic [63:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int checks;
    int failures;

    state_serializer dut (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .state_i  (state_i),
        .load_i   (load_i),
        .first_i  (first_i),
        .count_i  (count_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .last_o   (last_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] w(input int i);
        logic [3:0] n;
        n = i[3:0];
        return {16{n}};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {63'd0, valid_o}, 64'd0);
        chk({tag, "_busy"},  {63'd0, busy_o},  64'd0);
        chk({tag, "_last"},  {63'd0, last_o},  64'd0);
        chk({tag, "_data"},  data_o,           64'd0);
    endtask

    type_state st_w;
    type_state st_alt;
    type_state st_new;
    logic [63:0] exp_w [0:7];

    initial begin
        int k;
        int hsn;
        logic done_seen;
        logic [2:0] bad_f [0:2];
        logic [2:0] bad_c [0:2];

        checks   = 0;
        failures = 0;
        for (int i = 0; i < 5; i++) begin
            st_w[i]   = w(i);
            st_alt[i] = ~w(i);
            st_new[i] = 64'hDEAD_BEEF_0000_0000 + 64'(i + 1);
        end
        for (int i = 0; i < 8; i++) exp_w[i] = (i < 5) ? w(i) : 64'd0;
        bad_f[0] = 3'd4; bad_c[0] = 3'd2;
        bad_f[1] = 3'd0; bad_c[1] = 3'd0;
        bad_f[2] = 3'd5; bad_c[2] = 3'd0;

        resetb_i = 1'b0;
        state_i  = st_w;
        load_i   = 1'b0;
        first_i  = 3'd0;
        count_i  = 3'd0;
        ready_i  = 1'b0;

        // reset values
        #1;
        chk_idle("rst");
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_err",  {63'd0, err_o},  64'd0);
        @(negedge clock_i);
        @(negedge clock_i);
        resetb_i = 1'b1;

        // tag output: first=3 count=2, ready high
        @(negedge clock_i);
        load_i  = 1'b1;
        first_i = 3'd3;
        count_i = 3'd2;
        ready_i = 1'b1;
        @(negedge clock_i);
        load_i = 1'b0;
        chk("tag_v0",    {63'd0, valid_o}, 64'd1);
        chk("tag_busy0", {63'd0, busy_o},  64'd1);
        chk("tag_d0",    data_o,           w(3));
        chk("tag_l0",    {63'd0, last_o},  64'd0);
        @(negedge clock_i);
        chk("tag_d1",    data_o,           w(4));
        chk("tag_l1",    {63'd0, last_o},  64'd1);
        chk("tag_done0", {63'd0, done_o},  64'd0);
        @(negedge clock_i);
        chk("tag_done1", {63'd0, done_o},  64'd1);
        chk_idle("tag_end");

        // back-to-back: load in the done cycle, first=1 count=1
        load_i  = 1'b1;
        first_i = 3'd1;
        count_i = 3'd1;
        @(negedge clock_i);
        load_i = 1'b0;
        chk("b2b_done_low", {63'd0, done_o},  64'd0);
        chk("b2b_valid",    {63'd0, valid_o}, 64'd1);
        chk("b2b_data",     data_o,           w(1));
        chk("b2b_last",     {63'd0, last_o},  64'd1);
        @(negedge clock_i);
        chk("b2b_done", {63'd0, done_o}, 64'd1);
        chk_idle("b2b_end");

        // full dump with backpressure, plus a load and state change in SEND
        @(negedge clock_i);
        state_i = st_w;
        load_i  = 1'b1;
        first_i = 3'd0;
        count_i = 3'd5;
        ready_i = 1'b0;
        @(negedge clock_i);
        load_i    = 1'b0;
        k         = 0;
        hsn       = 0;
        done_seen = 1'b0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            if (c > 0) @(negedge clock_i);
            chk("dump_err", {63'd0, err_o}, 64'd0);
            if (done_o) begin
                done_seen = 1'b1;
            end else begin
                chk("dump_valid",   {63'd0, valid_o}, 64'd1);
                chk("dump_overrun", {63'd0, (k < 5)}, 64'd1);
                chk("dump_data",    data_o,           exp_w[k]);
                chk("dump_last",    {63'd0, last_o},  {63'd0, (k == 4)});
                if (c == 1) begin
                    load_i  = 1'b1;
                    state_i = st_alt;
                    first_i = 3'd0;
                    count_i = 3'd1;
                end else begin
                    load_i = 1'b0;
                end
                ready_i = (c % 3 == 0);
                if (ready_i) begin
                    hsn++;
                    k++;
                end
            end
        end
        chk("dump_done_seen", {63'd0, done_seen}, 64'd1);
        chk("dump_handshakes", 64'(hsn), 64'd5);
        chk_idle("dump_end");
        load_i  = 1'b0;
        ready_i = 1'b1;
        @(negedge clock_i);
        chk("dump_done_pulse", {63'd0, done_o}, 64'd0);

        // invalid configurations
        state_i = st_new;
        for (int i = 0; i < 3; i++) begin
            load_i  = 1'b1;
            first_i = bad_f[i];
            count_i = bad_c[i];
            @(negedge clock_i);
            load_i = 1'b0;
            chk("bad_err_hi", {63'd0, err_o},  64'd1);
            chk("bad_done",   {63'd0, done_o}, 64'd0);
            chk_idle("bad_hold");
            @(negedge clock_i);
            chk("bad_err_lo", {63'd0, err_o},  64'd0);
            chk_idle("bad_after");
        end

        // reset mid-run after two words
        state_i = st_w;
        load_i  = 1'b1;
        first_i = 3'd0;
        count_i = 3'd5;
        ready_i = 1'b1;
        @(negedge clock_i);
        load_i = 1'b0;
        chk("mid_d0", data_o, w(0));
        @(negedge clock_i);
        chk("mid_d1", data_o, w(1));
        @(negedge clock_i);
        chk("mid_d2", data_o, w(2));
        #1 resetb_i = 1'b0;
        #1;
        chk_idle("mid_rst");
        chk("mid_rst_done", {63'd0, done_o}, 64'd0);
        @(negedge clock_i);
        resetb_i = 1'b1;
        state_i  = st_new;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock_i);
            chk("mid_nodone", {63'd0, done_o}, 64'd0);
            chk_idle("mid_quiet");
        end
        load_i  = 1'b1;
        first_i = 3'd0;
        count_i = 3'd1;
        @(negedge clock_i);
        load_i = 1'b0;
        chk("mid_new_valid", {63'd0, valid_o}, 64'd1);
        chk("mid_new_data",  data_o,           st_new[0]);
        chk("mid_new_last",  {63'd0, last_o},  64'd1);
        @(negedge clock_i);
        chk("mid_new_done",  {63'd0, done_o},  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
